// File: rtl/sb_pkg.sv
// Shared types and default latencies for the issue-stage hazard scoreboard.
package sb_pkg;

    typedef enum logic {
        PIPE_SCALAR = 1'b0,
        PIPE_VECTOR = 1'b1
    } pipe_t;

    typedef enum logic {
        FILE_S = 1'b0,
        FILE_V = 1'b1
    } file_t;

    localparam int S_LAT_DEF = 3;
    localparam int V_LAT_DEF = 10;
    localparam int CNT_W     = $clog2(V_LAT_DEF + 1);

    function automatic int cnt_width(input int v_lat);
        return $clog2(v_lat + 1);
    endfunction

endpackage

// File: rtl/scoreboard_bank.sv
// One register file's pending-write counters and write-port slot reservations.
module scoreboard_bank #(
    parameter int V_LAT = 10,
    parameter int NREG  = 32,
    parameter int CW    = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          advance,
    input  logic [4:0]    src1,
    input  logic [4:0]    src2,
    input  logic [4:0]    dst,
    input  logic [CW-1:0] req_lat,
    input  logic          set_en,
    output logic          src1_pend,
    output logic          src2_pend,
    output logic [CW-1:0] dst_cnt,
    output logic          port_busy,
    output logic          busy
);

    logic [CW-1:0]    cnt [NREG];
    logic [V_LAT-1:0] res;
    logic [V_LAT-1:0] res_next;
    logic [V_LAT-1:0] slot_mask;

    always_comb begin
        slot_mask = '0;
        for (int k = 0; k < V_LAT; k++) begin
            slot_mask[k] = (req_lat == CW'(k + 1));
        end
        port_busy = |(res & slot_mask);
        // The edge itself consumes one cycle, so the new slot lands one bit lower.
        res_next = res >> 1;
        if (set_en) begin
            res_next = res_next | (slot_mask >> 1);
        end
    end

    always_comb begin
        src1_pend = (cnt[src1] != '0);
        src2_pend = (cnt[src2] != '0);
        dst_cnt   = cnt[dst];
        busy      = 1'b0;
        for (int r = 0; r < NREG; r++) begin
            busy = busy | (cnt[r] != '0);
        end
    end

    // Stored counts already reflect the cycle elapsing at this edge (L-1 after issue).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int r = 0; r < NREG; r++) begin
                cnt[r] <= '0;
            end
            res <= '0;
        end else if (advance) begin
            for (int r = 0; r < NREG; r++) begin
                if (set_en && (dst == 5'(r))) begin
                    cnt[r] <= req_lat - CW'(1);
                end else if (cnt[r] != '0) begin
                    cnt[r] <= cnt[r] - CW'(1);
                end
            end
            res <= res_next;
        end
    end

endmodule

// File: rtl/issue_scoreboard.sv
// Issue-stage hazard controller: blocks issue on RAW, WAW or writeback-port conflicts.
module issue_scoreboard
    import sb_pkg::*;
#(
    parameter int S_LAT = S_LAT_DEF,
    parameter int V_LAT = V_LAT_DEF,
    parameter int NREG  = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       issue_valid,
    input  logic       pipe_sel,
    input  logic       src1_en,
    input  logic       src2_en,
    input  logic       src1_file,
    input  logic       src2_file,
    input  logic [4:0] src1,
    input  logic [4:0] src2,
    input  logic       dst_we,
    input  logic       dst_file,
    input  logic [4:0] dst,
    input  logic       freeze,
    input  logic       flush,
    output logic       issue_fire,
    output logic       stall,
    output logic       hz_raw,
    output logic       hz_waw,
    output logic       hz_port,
    output logic       busy
);

    localparam int CW = cnt_width(V_LAT);

    logic [CW-1:0] lat;
    logic [1:0]    src1_pend;
    logic [1:0]    src2_pend;
    logic [1:0]    port_busy;
    logic [1:0]    bank_busy;
    logic [1:0]    set_en;
    logic [CW-1:0] dst_cnt [2];

    assign lat = (pipe_t'(pipe_sel) == PIPE_VECTOR) ? CW'(V_LAT) : CW'(S_LAT);

    always_comb begin
        hz_raw     = (src1_en & src1_pend[src1_file]) | (src2_en & src2_pend[src2_file]);
        hz_waw     = dst_we & (dst_cnt[dst_file] >= lat);
        hz_port    = dst_we & port_busy[dst_file];
        issue_fire = issue_valid & ~flush & ~freeze & ~hz_raw & ~hz_waw & ~hz_port;
        stall      = issue_valid & ~issue_fire;
        busy       = |bank_busy;
        set_en[0]  = issue_fire & dst_we & (file_t'(dst_file) == FILE_S);
        set_en[1]  = issue_fire & dst_we & (file_t'(dst_file) == FILE_V);
    end

    for (genvar f = 0; f < 2; f++) begin : g_bank
        scoreboard_bank #(
            .V_LAT (V_LAT),
            .NREG  (NREG),
            .CW    (CW)
        ) u_bank (
            .clk       (clk),
            .rst_n     (rst_n),
            .advance   (~freeze),
            .src1      (src1),
            .src2      (src2),
            .dst       (dst),
            .req_lat   (lat),
            .set_en    (set_en[f]),
            .src1_pend (src1_pend[f]),
            .src2_pend (src2_pend[f]),
            .dst_cnt   (dst_cnt[f]),
            .port_busy (port_busy[f]),
            .busy      (bank_busy[f])
        );
    end

endmodule
